// File: rtl/irq_pending_latch_if.sv
// Bundle of event, control and grant signals between the event sources,
// the consumer and the pending latch. The latch connects through 'slave'.
interface irq_pending_latch_if #(
  parameter int NSRC   = 7,
  parameter int DROP_W = 4
);
  logic [NSRC-1:0]   src;
  logic [NSRC-1:0]   mask_en;
  logic [NSRC-1:0]   clr;
  logic              irq_ack;
  logic [NSRC-1:0]   pending;
  logic              irq_valid;
  logic [2:0]        irq_id;
  logic [DROP_W-1:0] drop_cnt;

  modport master (
    output src, mask_en, clr, irq_ack,
    input  pending, irq_valid, irq_id, drop_cnt
  );

  modport slave (
    input  src, mask_en, clr, irq_ack,
    output pending, irq_valid, irq_id, drop_cnt
  );
endinterface

// File: rtl/irq_pending_latch.sv
// Seven-source event collector: rising-edge detect, per-source enable,
// sticky pending bits with write-1-to-clear, lowest-index grant served
// through a valid/ack handshake, and a saturating dropped-event counter.
module irq_pending_latch #(
  parameter int NSRC   = 7,
  parameter int DROP_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  irq_pending_latch_if.slave bus
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [NSRC-1:0]   src_q;
  logic [NSRC-1:0]   pending_q, pending_d;
  logic [2:0]        irq_id_q, irq_id_d;
  logic [DROP_W-1:0] drop_q, drop_d;

  logic [NSRC-1:0]   rise;
  logic [NSRC-1:0]   set_vec;
  logic [NSRC-1:0]   ack_onehot;
  logic [NSRC-1:0]   clr_eff;
  logic [NSRC-1:0]   lost;
  logic              ack_fire;
  logic [2:0]        lowest_id;

  // A grant is being presented whenever the FSM sits in GRANT.
  assign ack_fire = (state_q == GRANT) && bus.irq_ack;

  // Edge detection, enable gating and the combined clear vector.
  always_comb begin
    rise       = bus.src & ~src_q;
    set_vec    = rise & bus.mask_en;
    ack_onehot = '0;
    for (int i = 0; i < NSRC; i++) begin
      ack_onehot[i] = ack_fire && (irq_id_q == 3'(i));
    end
    clr_eff    = bus.clr | ack_onehot;
    lost       = set_vec & pending_q & ~clr_eff;
  end

  // Pending update: a new event wins over a same-cycle clear.
  always_comb begin
    pending_d = (pending_q & ~clr_eff) | set_vec;
  end

  // Dropped-event count: one per cycle with any lost edge, sticks at all-ones.
  always_comb begin
    drop_d = drop_q;
    if ((|lost) && (drop_q != {DROP_W{1'b1}})) begin
      drop_d = drop_q + DROP_W'(1);
    end
  end

  // Lowest-index pending source, scanned high to low so index 0 wins.
  always_comb begin
    lowest_id = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (pending_q[i]) begin
        lowest_id = 3'(i);
      end
    end
  end

  // Grant FSM: arbitrate only when leaving IDLE, hold the id while granted.
  always_comb begin
    state_d  = state_q;
    irq_id_d = irq_id_q;
    case (state_q)
      IDLE: begin
        if (|pending_q) begin
          irq_id_d = lowest_id;
          state_d  = GRANT;
        end
      end
      GRANT: begin
        if (bus.irq_ack) begin
          state_d = IDLE;
        end else if (bus.clr[irq_id_q]) begin
          // Software withdrew the granted bit; abandon this grant.
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; src_q resets high so lines already high do not fire.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      src_q     <= '1;
      pending_q <= '0;
      irq_id_q  <= '0;
      drop_q    <= '0;
    end else begin
      state_q   <= state_d;
      src_q     <= bus.src;
      pending_q <= pending_d;
      irq_id_q  <= irq_id_d;
      drop_q    <= drop_d;
    end
  end

  assign bus.pending   = pending_q;
  assign bus.irq_valid = (state_q == GRANT);
  assign bus.irq_id    = irq_id_q;
  assign bus.drop_cnt  = drop_q;

endmodule

// File: tb/tb_irq_pending_latch.sv
// Self-checking bench for irq_pending_latch: directed scenarios plus a
// randomized run, all compared against an event-level reference model.
module tb_irq_pending_latch;

  logic clk;
  logic rst_n;

  irq_pending_latch_if #(.NSRC(7), .DROP_W(4)) bus ();

  irq_pending_latch #(.NSRC(7), .DROP_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int failures;

  // Reference model state: pending flags, last-seen line levels,
  // granted source (-1 when none), last granted id, dropped count.
  bit m_pend [7];
  bit m_prev [7];
  int m_grant;
  int m_id;
  int m_drop;

  function automatic logic [6:0] model_pending();
    logic [6:0] v;
    for (int i = 0; i < 7; i++) v[i] = m_pend[i];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 7; i++) begin
      m_pend[i] = 1'b0;
      m_prev[i] = 1'b1;
    end
    m_grant = -1;
    m_id    = 0;
    m_drop  = 0;
  endtask

  // One clock edge of behaviour, evaluated from the inputs seen at the edge.
  task automatic model_step();
    bit old_pend [7];
    bit any_lost;
    bit rise, setb, clri;
    int ng;
    any_lost = 1'b0;
    for (int i = 0; i < 7; i++) old_pend[i] = m_pend[i];
    for (int i = 0; i < 7; i++) begin
      rise = bus.src[i] && !m_prev[i];
      setb = rise && bus.mask_en[i];
      clri = bus.clr[i] || (m_grant == i && bus.irq_ack);
      if (setb && old_pend[i] && !clri) any_lost = 1'b1;
      m_pend[i] = setb || (old_pend[i] && !clri);
      m_prev[i] = bus.src[i];
    end
    if (any_lost && m_drop < 15) m_drop++;
    ng = m_grant;
    if (m_grant < 0) begin
      for (int i = 6; i >= 0; i--) if (old_pend[i]) ng = i;
      if (ng >= 0) m_id = ng;
    end else if (bus.irq_ack) begin
      $display("txn ack id=%0d time=%0t", m_grant, $time);
      ng = -1;
    end else if (bus.clr[m_grant]) begin
      $display("txn cancel id=%0d time=%0t", m_grant, $time);
      ng = -1;
    end
    m_grant = ng;
  endtask

  // Advance one clock, update the model and compare every output.
  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    checks++;
    if (bus.pending !== model_pending()) begin
      failures++;
      $display("FAIL pending got=%h exp=%h t=%0t", bus.pending, model_pending(), $time);
    end
    checks++;
    if (bus.irq_valid !== (m_grant >= 0)) begin
      failures++;
      $display("FAIL irq_valid got=%b exp=%b t=%0t", bus.irq_valid, (m_grant >= 0), $time);
    end
    checks++;
    if (bus.irq_id !== 3'(m_id)) begin
      failures++;
      $display("FAIL irq_id got=%0d exp=%0d t=%0t", bus.irq_id, m_id, $time);
    end
    checks++;
    if (bus.drop_cnt !== 4'(m_drop)) begin
      failures++;
      $display("FAIL drop_cnt got=%0d exp=%0d t=%0t", bus.drop_cnt, m_drop, $time);
    end
  endtask

  task automatic wait_valid(input int budget, input string name);
    int n;
    n = 0;
    while (bus.irq_valid !== 1'b1 && n < budget) begin
      cycle();
      n++;
    end
    checks++;
    if (bus.irq_valid !== 1'b1) begin
      failures++;
      $display("FAIL %s timeout got_valid=%b exp=1", name, bus.irq_valid);
    end
  endtask

  task automatic do_reset(input logic [6:0] s, input logic [6:0] m);
    bus.src     = s;
    bus.mask_en = m;
    bus.clr     = '0;
    bus.irq_ack = 1'b0;
    rst_n       = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset(7'h7F, 7'h7F);
    for (int k = 0; k < 10; k++) cycle();
    checks++;
    if (bus.pending !== 7'h00 || bus.irq_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_quiet got pending=%h valid=%b exp 00/0", bus.pending, bus.irq_valid);
    end
  endtask

  task automatic test_single();
    do_reset(7'h00, 7'h10);
    cycle();
    bus.src = 7'h10;
    cycle();
    bus.src = 7'h00;
    checks++;
    if (bus.pending !== 7'h10 || bus.irq_valid !== 1'b0) begin
      failures++;
      $display("FAIL single_latch got pending=%h valid=%b exp 10/0", bus.pending, bus.irq_valid);
    end
    cycle();
    checks++;
    if (bus.irq_valid !== 1'b1 || bus.irq_id !== 3'd4) begin
      failures++;
      $display("FAIL single_grant got valid=%b id=%0d exp 1/4", bus.irq_valid, bus.irq_id);
    end
    bus.irq_ack = 1'b1;
    cycle();
    bus.irq_ack = 1'b0;
    checks++;
    if (bus.pending !== 7'h00 || bus.irq_valid !== 1'b0) begin
      failures++;
      $display("FAIL single_ack got pending=%h valid=%b exp 00/0", bus.pending, bus.irq_valid);
    end
  endtask

  task automatic test_priority();
    int order [3];
    order = '{0, 2, 6};
    do_reset(7'h00, 7'h7F);
    cycle();
    bus.src = 7'h45;
    cycle();
    bus.src = 7'h00;
    for (int k = 0; k < 3; k++) begin
      wait_valid(8, "prio_wait");
      checks++;
      if (bus.irq_id !== 3'(order[k])) begin
        failures++;
        $display("FAIL prio_order got id=%0d exp=%0d", bus.irq_id, order[k]);
      end
      cycle();
      cycle();
      checks++;
      if (bus.irq_valid !== 1'b1 || bus.irq_id !== 3'(order[k])) begin
        failures++;
        $display("FAIL prio_hold got valid=%b id=%0d exp 1/%0d", bus.irq_valid, bus.irq_id, order[k]);
      end
      bus.irq_ack = 1'b1;
      cycle();
      bus.irq_ack = 1'b0;
      checks++;
      if (bus.irq_valid !== 1'b0) begin
        failures++;
        $display("FAIL prio_idle_gap got valid=%b exp=0", bus.irq_valid);
      end
    end
  endtask

  task automatic test_masked();
    do_reset(7'h00, 7'h77);
    cycle();
    bus.src = 7'h08;
    cycle();
    bus.src = 7'h00;
    bus.mask_en = 7'h7F;
    for (int k = 0; k < 4; k++) cycle();
    checks++;
    if (bus.pending[3] !== 1'b0 || bus.irq_valid !== 1'b0) begin
      failures++;
      $display("FAIL masked_edge got pend3=%b valid=%b exp 0/0", bus.pending[3], bus.irq_valid);
    end
  endtask

  task automatic test_clr_cancel();
    do_reset(7'h00, 7'h7F);
    cycle();
    bus.src = 7'h02;
    cycle();
    bus.src = 7'h00;
    wait_valid(8, "clr_wait");
    checks++;
    if (bus.irq_id !== 3'd1) begin
      failures++;
      $display("FAIL clr_grant_id got=%0d exp=1", bus.irq_id);
    end
    bus.clr = 7'h22;
    bus.src = 7'h20;
    cycle();
    bus.clr = 7'h00;
    bus.src = 7'h00;
    checks++;
    if (bus.irq_valid !== 1'b0 || bus.pending[1] !== 1'b0 || bus.pending[5] !== 1'b1) begin
      failures++;
      $display("FAIL clr_cancel got valid=%b pend=%h exp 0/20", bus.irq_valid, bus.pending);
    end
    wait_valid(8, "clr_regrant");
    checks++;
    if (bus.irq_id !== 3'd5) begin
      failures++;
      $display("FAIL clr_regrant_id got=%0d exp=5", bus.irq_id);
    end
  endtask

  task automatic test_drop_and_reset();
    do_reset(7'h00, 7'h7F);
    cycle();
    bus.src = 7'h04;
    cycle();
    bus.src = 7'h00;
    wait_valid(8, "drop_wait");
    for (int k = 0; k < 20; k++) begin
      bus.src = 7'h04;
      cycle();
      bus.src = 7'h00;
      cycle();
    end
    checks++;
    if (bus.drop_cnt !== 4'd15 || bus.irq_valid !== 1'b1 || bus.irq_id !== 3'd2) begin
      failures++;
      $display("FAIL drop_sat got cnt=%0d valid=%b id=%0d exp 15/1/2", bus.drop_cnt, bus.irq_valid, bus.irq_id);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.pending !== 7'h00 || bus.irq_valid !== 1'b0 || bus.irq_id !== 3'd0 || bus.drop_cnt !== 4'd0) begin
      failures++;
      $display("FAIL async_reset got pend=%h valid=%b id=%0d cnt=%0d exp all 0",
               bus.pending, bus.irq_valid, bus.irq_id, bus.drop_cnt);
    end
    do_reset(7'h00, 7'h7F);
    for (int k = 0; k < 3; k++) cycle();
  endtask

  task automatic test_random();
    do_reset(7'h00, 7'h7F);
    for (int k = 0; k < 600; k++) begin
      bus.src     = 7'($urandom_range(0, 127));
      bus.mask_en = 7'($urandom_range(0, 127));
      bus.clr     = ($urandom_range(0, 7) == 0) ? 7'($urandom_range(0, 127)) : 7'h00;
      bus.irq_ack = 1'($urandom_range(0, 1));
      cycle();
    end
    bus.src     = 7'h00;
    bus.clr     = 7'h00;
    bus.irq_ack = 1'b1;
    for (int k = 0; k < 20; k++) cycle();
    bus.irq_ack = 1'b0;
    checks++;
    if (bus.pending !== 7'h00) begin
      failures++;
      $display("FAIL random_drain got pend=%h exp=00", bus.pending);
    end
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    rst_n       = 1'b0;
    bus.src     = '0;
    bus.mask_en = '0;
    bus.clr     = '0;
    bus.irq_ack = 1'b0;
    test_reset();
    test_single();
    test_priority();
    test_masked();
    test_clr_cancel();
    test_drop_and_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
